// File: rtl/yin_threshold_picker.sv
// yin_threshold_picker: picks the YIN lag from a CMND results vector (first sub-threshold dip, else global min)
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   start         level request, sampled only while idle (tie to upstream ready)
//   results       MAX_TAU entries, entry t at [t*IDW +: IDW], unsigned
//   threshold     absolute threshold, sampled with start
//   busy          high while a frame is being processed, including the done cycle
//   done          one-cycle pulse; found/tau_out/min_value valid from this cycle
//   found         1 = threshold hit (voiced), 0 = global-minimum fallback
//   tau_out       selected lag
//   min_value     results entry at tau_out
module yin_threshold_picker #(
    parameter int INTERMEDIATE_DATA_WIDTH = 64,
    parameter int MAX_TAU = 40,
    parameter int TAU_BITS = 6
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       start,
    input  logic [MAX_TAU*INTERMEDIATE_DATA_WIDTH-1:0] results,
    input  logic [INTERMEDIATE_DATA_WIDTH-1:0]         threshold,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       found,
    output logic [TAU_BITS-1:0]                        tau_out,
    output logic [INTERMEDIATE_DATA_WIDTH-1:0]         min_value
);
    localparam int IDW = INTERMEDIATE_DATA_WIDTH;
    localparam logic [TAU_BITS-1:0] LAST = TAU_BITS'(MAX_TAU - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DESCEND, DONE} state_t;

    state_t              state_q, state_d;
    logic [IDW-1:0]      snap_q [MAX_TAU];
    logic [IDW-1:0]      thr_q;
    logic [TAU_BITS-1:0] idx_q, idx_d, best_idx_q, best_idx_d, tau_q, tau_d, idx_inc;
    logic [IDW-1:0]      best_val_q, best_val_d, min_q, min_d, v, v_next;
    logic                busy_q, busy_d, done_q, done_d, found_q, found_d;
    logic                load, last, hit, better, falling, stop, fallback;

    assign load     = state_q == IDLE && start;
    assign last     = idx_q == LAST;
    assign idx_inc  = last ? idx_q : idx_q + 1'b1;
    assign v        = snap_q[idx_q];
    assign v_next   = snap_q[idx_inc];
    // idx starts at 0 so entry k is examined in the cycle after edge k; slot 0 is a skip cycle
    assign hit      = state_q == SCAN && idx_q != '0 && v < thr_q;
    assign better   = state_q == SCAN && idx_q != '0 && v < best_val_q;
    assign falling  = !last && v_next < v;
    assign stop     = state_q == DESCEND && !falling;
    assign fallback = state_q == SCAN && !hit && last;

    // snapshot so upstream may change results right after the start edge
    always_ff @(posedge clk) begin
        if (!reset && load) begin
            for (int t = 0; t < MAX_TAU; t++) snap_q[t] <= results[t*IDW +: IDW];
            thr_q <= threshold;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_val_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            found_q    <= 1'b0;
            tau_q      <= '0;
            min_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            best_idx_q <= best_idx_d;
            best_val_q <= best_val_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            found_q    <= found_d;
            tau_q      <= tau_d;
            min_q      <= min_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? SCAN : IDLE;
            SCAN:    state_d = hit ? DESCEND : last ? DONE : SCAN;
            DESCEND: state_d = falling ? DESCEND : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d      = load ? '0 : ((state_q == SCAN && !hit) || (state_q == DESCEND && falling)) ? idx_inc : idx_q;
        // strict compare keeps the lowest tau among equal minima
        best_idx_d = load ? TAU_BITS'(1) : better ? idx_q : best_idx_q;
        best_val_d = load ? results[IDW +: IDW] : better ? v : best_val_q;
        busy_d     = state_d != IDLE;
        done_d     = state_d == DONE;
        found_d    = stop ? 1'b1 : fallback ? 1'b0 : found_q;
        tau_d      = stop ? idx_q : fallback ? best_idx_d : tau_q;
        min_d      = stop ? v : fallback ? best_val_d : min_q;
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign found     = found_q;
    assign tau_out   = tau_q;
    assign min_value = min_q;
endmodule

// File: tb/tb_yin_threshold_picker.sv
// tb_yin_threshold_picker: scoreboard bench for yin_threshold_picker with directed and random frames
module tb_yin_threshold_picker;
    localparam int IDW = 64;
    localparam int MT  = 40;
    localparam int TB  = 6;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [MT*IDW-1:0] results = '0;
    logic [IDW-1:0]    threshold = '0;
    logic              busy, done, found;
    logic [TB-1:0]     tau_out;
    logic [IDW-1:0]    min_value;

    yin_threshold_picker #(.INTERMEDIATE_DATA_WIDTH(IDW), .MAX_TAU(MT), .TAU_BITS(TB)) dut (
        .clk(clk), .reset(reset), .start(start), .results(results), .threshold(threshold),
        .busy(busy), .done(done), .found(found), .tau_out(tau_out), .min_value(min_value)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic           f;
        logic [TB-1:0]  t;
        logic [IDW-1:0] v;
        int             at;
    } exp_t;

    exp_t           sbq[$];
    int             nvec = 0;
    int             nerr = 0;
    logic [IDW-1:0] ent [MT];

    task automatic check(input string name, input logic [IDW-1:0] act, input logic [IDW-1:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: first entry below thr, then walk downhill; else first occurrence of the global minimum.
    // at = cycle count at which done must be visible, given start was sampled at cycle s0.
    function automatic exp_t model(input logic [IDW-1:0] thr, input int s0);
        exp_t e;
        int first = -1;
        int gmin = 1;
        int m;
        for (int k = 1; k < MT; k++) if (ent[k] < ent[gmin]) gmin = k;
        for (int k = 1; k < MT; k++) if (ent[k] < thr) begin first = k; break; end
        if (first < 0) begin
            e.f = 1'b0; e.t = TB'(gmin); e.v = ent[gmin]; e.at = s0 + MT;
        end else begin
            m = first;
            while (m < MT - 1 && ent[m+1] < ent[m]) m++;
            e.f = 1'b1; e.t = TB'(m); e.v = ent[m]; e.at = s0 + m + 2;
        end
        return e;
    endfunction

    task automatic put_results();
        for (int t = 0; t < MT; t++) results[t*IDW +: IDW] = ent[t];
    endtask

    task automatic scramble();
        for (int t = 0; t < MT; t++) results[t*IDW +: IDW] = {$urandom, $urandom};
        threshold = {$urandom, $urandom};
    endtask

    // drive one start, optionally push the expectation; returns the cycle of the start edge
    task automatic launch(input logic [IDW-1:0] thr, input bit push, input bit hold, output int s0);
        put_results();
        threshold = thr;
        start = 1'b1;
        @(posedge clk);
        #1;
        s0 = cyc;
        if (push) sbq.push_back(model(thr, s0));
        if (!hold) begin
            start = 1'b0;
            scramble();
        end
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 300 && sbq.size() != 0; i++) @(negedge clk);
        if (sbq.size() != 0) begin
            nvec++;
            nerr++;
            $display("FAIL timeout: %0d results still pending, expected 0", sbq.size());
            sbq.delete();
        end
        @(negedge clk);
    endtask

    task automatic fill(input logic [IDW-1:0] val);
        for (int t = 0; t < MT; t++) ent[t] = val;
    endtask

    task automatic setup_t2();
        fill(1000);
        ent[10] = 50; ent[11] = 30; ent[12] = 40;
    endtask

    initial begin
        bit   pd = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                check("done_single_cycle", pd, 0);
                check("busy_with_done", busy, 1);
                if (sbq.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
                end else begin
                    e = sbq.pop_front();
                    check("found", found, e.f);
                    check("tau_out", tau_out, e.t);
                    check("min_value", min_value, e.v);
                    check("done_cycle", cyc, e.at);
                end
            end
            pd = done;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        logic [IDW-1:0] thr;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_found", found, 0);
        check("rst_tau", tau_out, 0);
        check("rst_min", min_value, 0);
        reset = 1'b0;
        @(negedge clk);

        fill(1000);
        launch(100, 1, 0, s0);
        wait_empty();

        setup_t2();
        launch(100, 1, 0, s0);
        wait_empty();

        fill(1000);
        for (int t = 20; t < MT; t++) ent[t] = 90 - (t - 20);
        launch(100, 1, 0, s0);
        wait_empty();

        setup_t2();
        launch(100, 0, 0, s0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_found", found, 0);
        check("midrst_tau", tau_out, 0);
        check("midrst_min", min_value, 0);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        setup_t2();
        launch(100, 1, 0, s0);
        wait_empty();

        setup_t2();
        launch(100, 1, 1, s0);
        fill(1000);
        put_results();
        sbq.push_back(model(100, s0 + 15));
        repeat (16) @(negedge clk);
        start = 1'b0;
        wait_empty();

        fill(500);
        ent[5] = 200; ent[7] = 200;
        launch(0, 1, 0, s0);
        wait_empty();

        for (int n = 0; n < 40; n++) begin
            bit wide = ($urandom_range(0, 3) == 0);
            for (int t = 0; t < MT; t++)
                ent[t] = wide ? {32'($urandom_range(0, 3)), $urandom} : IDW'($urandom_range(0, 400));
            thr = ($urandom_range(0, 4) == 0) ? '0 :
                  wide ? {32'($urandom_range(0, 2)), $urandom} : IDW'($urandom_range(0, 200));
            launch(thr, 1, 0, s0);
            wait_empty();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
